// File: rtl/ising_run_ctrl.sv
// Run controller for the Ising core: loads coupling weights, sequences the
// core reset/run window, and hands back the sampled phase vector.
module ising_run_ctrl #(
    parameter  int N            = 3,
    parameter  int NUM_WEIGHTS  = 5,
    parameter  int RESET_CYCLES = 4,
    parameter  int RUN_CYCLES   = 64,
    localparam int WB = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
    localparam int NC = N * (N - 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reuse_weights,
    input  logic             wt_valid,
    input  logic [WB-1:0]    wt_data,
    output logic             wt_ready,
    output logic [WB*NC-1:0] weights,
    output logic             ising_rstn,
    input  logic [N-1:0]     phase_in,
    output logic             result_valid,
    output logic [N-1:0]     result_phase,
    input  logic             result_ready,
    output logic             busy
);

    localparam int IW   = (NC > 1) ? $clog2(NC) : 1;
    localparam int MAXC = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [WB-1:0] WMAX = WB'(NUM_WEIGHTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic          beat;
    logic [WB-1:0] wt_sat;

    assign wt_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign wt_sat   = (wt_data > WMAX) ? WMAX : wt_data;

    always_comb begin
        state_d = state_q;
        beat    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = reuse_weights ? S_HOLD : S_LOAD;
            end
            S_LOAD: begin
                if (wt_valid) begin
                    beat = 1'b1;
                    if (idx_q == IW'(NC - 1))
                        state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(RESET_CYCLES - 1))
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == CW'(RUN_CYCLES - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (result_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            weights      <= '0;
            result_phase <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            ising_rstn   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            ising_rstn <= (state_d == S_RUN);

            // Counter restarts on every state change and saturates otherwise.
            if (state_q != state_d)
                cnt_q <= '0;
            else if (cnt_q != CW'(MAXC))
                cnt_q <= cnt_q + 1'b1;

            if (state_q == S_IDLE)
                idx_q <= '0;
            else if (beat) begin
                weights[idx_q*WB +: WB] <= wt_sat;
                idx_q <= idx_q + 1'b1;
            end

            if (state_q == S_RUN && state_d == S_DONE) begin
                result_phase <= phase_in;
                result_valid <= 1'b1;
            end else if (state_q == S_DONE && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule
